// File: rtl/note_rec_bank_pkg.sv
// -----------------------------------------------------------------------------
// note_rec_bank_pkg
// Shared constants for the multi-slot note recorder/player:
//   - default field widths of a note entry {octave, note, length, full_note}
//   - command encodings on the mode input (none / REC / PLAY / CLEAR)
//   - FSM state encoding
//   - idle values presented on the read fields after reset
//   - helper computing the slot-select width
// No ports (package).
// -----------------------------------------------------------------------------
package note_rec_bank_pkg;

   localparam int DEF_SLOTS          = 4;
   localparam int DEF_DEPTH_BITS     = 5;
   localparam int DEF_OCTAVE_BITS    = 3;
   localparam int DEF_NOTE_BITS      = 3;
   localparam int DEF_LENGTH_BITS    = 3;
   localparam int DEF_FULL_NOTE_BITS = 3;

   localparam logic [1:0] MODE_NONE  = 2'b00;
   localparam logic [1:0] MODE_REC   = 2'b01;
   localparam logic [1:0] MODE_PLAY  = 2'b10;
   localparam logic [1:0] MODE_CLEAR = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_REC  = 2'b01,
      ST_PLAY = 2'b10
   } state_t;

   // Read-field values shown while nothing has been played yet
   localparam int RST_OCTAVE    = 4;
   localparam int RST_FULL_NOTE = 4;

   // Width of the slot selector; a single-slot bank still carries one bit
   function automatic int slot_bits(input int slots);
      return (slots > 1) ? $clog2(slots) : 1;
   endfunction

endpackage

// File: rtl/note_rec_bank_if.sv
// -----------------------------------------------------------------------------
// note_rec_bank_if
// Command, write-stream, read-stream and status signals of note_rec_bank.
//   slave  modport : the recorder bank (commands/write entries in, read
//                    entries and status out)
//   master modport : the controller/keyboard/player side
// Signals: mode, slot_sel, start, stop, wr_valid/wr_ready + wr_* fields,
//          rd_valid/rd_ready + rd_* fields, count, busy, full, done.
// -----------------------------------------------------------------------------
interface note_rec_bank_if
   import note_rec_bank_pkg::*;
#(
   parameter int SLOTS          = DEF_SLOTS,
   parameter int DEPTH_BITS     = DEF_DEPTH_BITS,
   parameter int OCTAVE_BITS    = DEF_OCTAVE_BITS,
   parameter int NOTE_BITS      = DEF_NOTE_BITS,
   parameter int LENGTH_BITS    = DEF_LENGTH_BITS,
   parameter int FULL_NOTE_BITS = DEF_FULL_NOTE_BITS
);
   localparam int SB = slot_bits(SLOTS);

   logic [1:0]                mode;
   logic [SB-1:0]             slot_sel;
   logic                      start;
   logic                      stop;
   logic                      wr_valid;
   logic                      wr_ready;
   logic [OCTAVE_BITS-1:0]    wr_octave;
   logic [NOTE_BITS-1:0]      wr_note;
   logic [LENGTH_BITS-1:0]    wr_length;
   logic [FULL_NOTE_BITS-1:0] wr_full_note;
   logic                      rd_valid;
   logic                      rd_ready;
   logic [OCTAVE_BITS-1:0]    rd_octave;
   logic [NOTE_BITS-1:0]      rd_note;
   logic [LENGTH_BITS-1:0]    rd_length;
   logic [FULL_NOTE_BITS-1:0] rd_full_note;
   logic [DEPTH_BITS:0]       count;
   logic                      busy;
   logic                      full;
   logic                      done;

   modport slave (
      input  mode, slot_sel, start, stop,
      input  wr_valid, wr_octave, wr_note, wr_length, wr_full_note,
      output wr_ready,
      output rd_valid, rd_octave, rd_note, rd_length, rd_full_note,
      input  rd_ready,
      output count, busy, full, done
   );

   modport master (
      output mode, slot_sel, start, stop,
      output wr_valid, wr_octave, wr_note, wr_length, wr_full_note,
      input  wr_ready,
      input  rd_valid, rd_octave, rd_note, rd_length, rd_full_note,
      output rd_ready,
      input  count, busy, full, done
   );

endinterface

// File: rtl/note_rec_ram.sv
// -----------------------------------------------------------------------------
// note_rec_ram
// Single-clock simple dual-port RAM holding every slot's note entries.
// One write port, one read port with a registered output (one-cycle
// latency). Contents are not reset.
// Ports:
//   clk      in  clock
//   i_we     in  write enable
//   i_waddr  in  write address {slot, entry}
//   i_wdata  in  write data
//   i_raddr  in  read address {slot, entry}
//   o_rdata  out read data, valid the cycle after i_raddr is presented
// -----------------------------------------------------------------------------
module note_rec_ram #(
   parameter int ADDR_W = 7,
   parameter int DATA_W = 12,
   parameter int DEPTH  = 128
) (
   input  logic              clk,
   input  logic              i_we,
   input  logic [ADDR_W-1:0] i_waddr,
   input  logic [DATA_W-1:0] i_wdata,
   input  logic [ADDR_W-1:0] i_raddr,
   output logic [DATA_W-1:0] o_rdata
);
   logic [DATA_W-1:0] r_mem [DEPTH];
   logic [DATA_W-1:0] r_rdata;

   // Storage write port and registered read port
   always_ff @(posedge clk) begin
      if (i_we) begin
         r_mem[i_waddr] <= i_wdata;
      end
      r_rdata <= r_mem[i_raddr];
   end

   assign o_rdata = r_rdata;

endmodule

// File: rtl/note_rec_bank.sv
// -----------------------------------------------------------------------------
// note_rec_bank
// Multi-slot note recorder/player. Records a valid/ready stream of note
// entries into a chosen slot, plays a slot back as a valid/ready stream and
// keeps the length of every slot.
// Ports:
//   clk    in  clock, all state on the rising edge
//   rst_n  in  asynchronous active-low reset
//   bus    note_rec_bank_if.slave : commands, write stream, read stream,
//          count / busy / full / done status
// Build option: NOTE_REC_LOOP_EN -- when defined, PLAY repeats the slot until
// stop instead of finishing after one pass.
// -----------------------------------------------------------------------------
module note_rec_bank
   import note_rec_bank_pkg::*;
#(
   parameter int SLOTS          = DEF_SLOTS,
   parameter int DEPTH_BITS     = DEF_DEPTH_BITS,
   parameter int OCTAVE_BITS    = DEF_OCTAVE_BITS,
   parameter int NOTE_BITS      = DEF_NOTE_BITS,
   parameter int LENGTH_BITS    = DEF_LENGTH_BITS,
   parameter int FULL_NOTE_BITS = DEF_FULL_NOTE_BITS
) (
   input  logic           clk,
   input  logic           rst_n,
   note_rec_bank_if.slave bus
);
   localparam int SB = slot_bits(SLOTS);
   localparam int PB = DEPTH_BITS + 1;
   localparam int W  = OCTAVE_BITS + NOTE_BITS + LENGTH_BITS + FULL_NOTE_BITS;
   localparam int AW = SB + DEPTH_BITS;
   localparam logic [PB-1:0] C_ONE = {{DEPTH_BITS{1'b0}}, 1'b1};

`ifdef NOTE_REC_LOOP_EN
   localparam bit LOOP_EN = 1'b1;
`else
   localparam bit LOOP_EN = 1'b0;
`endif

   state_t                    r_state;
   state_t                    w_state_nxt;
   logic [SB-1:0]             r_slot;
   logic [PB-1:0]             r_wr_ptr;
   logic [PB-1:0]             w_wr_ptr_nxt;
   logic [PB-1:0]             r_rd_ptr;
   logic [PB-1:0]             r_delivered;
   logic [PB-1:0]             r_len [SLOTS];
   logic                      r_pend;
   logic                      r_wr_ready;
   logic                      r_full;
   logic                      r_busy;
   logic                      r_done;
   logic                      r_rd_valid;
   logic [OCTAVE_BITS-1:0]    r_rd_octave;
   logic [NOTE_BITS-1:0]      r_rd_note;
   logic [LENGTH_BITS-1:0]    r_rd_length;
   logic [FULL_NOTE_BITS-1:0] r_rd_full_note;

   logic          w_slot_ok;
   logic [PB-1:0] w_sel_len;
   logic [PB-1:0] w_cur_len;
   logic          w_wr_hs;
   logic          w_rd_hs;
   logic          w_issue;
   logic          w_done_nxt;
   logic          w_clear;
   logic          w_start_rec;
   logic          w_start_play;
   logic [PB-1:0] w_count;
   logic [W-1:0]  w_ram_q;

   // Slots beyond SLOTS (non power-of-two banks) are treated as absent
   assign w_slot_ok = (int'(bus.slot_sel) < SLOTS);
   assign w_sel_len = w_slot_ok ? r_len[bus.slot_sel] : '0;
   assign w_cur_len = r_len[r_slot];
   assign w_wr_hs   = bus.wr_valid && r_wr_ready;
   assign w_rd_hs   = r_rd_valid && bus.rd_ready;

   // One fetch in flight at most, and only when the output register is free
   // or being drained this cycle, so presented data is never overwritten.
   assign w_issue = (r_state == ST_PLAY) && !bus.stop && (r_rd_ptr < w_cur_len)
                    && !r_pend && (!r_rd_valid || bus.rd_ready);

   // Next-state and command decode
   always_comb begin
      w_state_nxt  = r_state;
      w_done_nxt   = 1'b0;
      w_clear      = 1'b0;
      w_start_rec  = 1'b0;
      w_start_play = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (bus.start && w_slot_ok) begin
               case (bus.mode)
                  MODE_NONE: w_state_nxt = ST_IDLE;
                  MODE_REC: begin
                     w_state_nxt = ST_REC;
                     w_start_rec = 1'b1;
                  end
                  MODE_PLAY: begin
                     // An empty slot completes immediately without leaving IDLE
                     if (w_sel_len == '0) begin
                        w_done_nxt = 1'b1;
                     end else begin
                        w_state_nxt  = ST_PLAY;
                        w_start_play = 1'b1;
                     end
                  end
                  MODE_CLEAR: w_clear = 1'b1;
                  default:    w_state_nxt = ST_IDLE;
               endcase
            end else begin
               w_state_nxt = ST_IDLE;
            end
         end
         ST_REC: begin
            if (bus.stop) begin
               w_state_nxt = ST_IDLE;
               w_done_nxt  = 1'b1;
            end else begin
               w_state_nxt = ST_REC;
            end
         end
         ST_PLAY: begin
            if (bus.stop) begin
               w_state_nxt = ST_IDLE;
               w_done_nxt  = 1'b1;
            end else if (!LOOP_EN && w_rd_hs && ((r_delivered + C_ONE) == w_cur_len)) begin
               w_state_nxt = ST_IDLE;
               w_done_nxt  = 1'b1;
            end else begin
               w_state_nxt = ST_PLAY;
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   // Write pointer next value; a handshake in the stop cycle still counts
   always_comb begin
      w_wr_ptr_nxt = r_wr_ptr;
      if (w_start_rec) begin
         w_wr_ptr_nxt = '0;
      end else if (w_wr_hs) begin
         w_wr_ptr_nxt = r_wr_ptr + C_ONE;
      end else begin
         w_wr_ptr_nxt = r_wr_ptr;
      end
   end

   // Progress shown on count depends on what the bank is doing
   always_comb begin
      w_count = w_sel_len;
      case (r_state)
         ST_REC:  w_count = r_wr_ptr;
         ST_PLAY: w_count = r_delivered;
         default: w_count = w_sel_len;
      endcase
   end

   // FSM state, latched slot and registered status outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= ST_IDLE;
         r_slot     <= '0;
         r_wr_ptr   <= '0;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
         r_wr_ready <= 1'b0;
         r_full     <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         if (w_start_rec || w_start_play) begin
            r_slot <= bus.slot_sel;
         end
         r_wr_ptr   <= w_wr_ptr_nxt;
         r_busy     <= (w_state_nxt != ST_IDLE);
         r_done     <= w_done_nxt;
         r_wr_ready <= (w_state_nxt == ST_REC) && !w_wr_ptr_nxt[DEPTH_BITS];
         r_full     <= (w_state_nxt == ST_REC) && w_wr_ptr_nxt[DEPTH_BITS];
      end
   end

   // Per-slot song length: cleared by CLEAR, set when a recording stops
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < SLOTS; i++) begin
            r_len[i] <= '0;
         end
      end else begin
         for (int i = 0; i < SLOTS; i++) begin
            if (w_clear && (bus.slot_sel == SB'(i))) begin
               r_len[i] <= '0;
            end else if ((r_state == ST_REC) && bus.stop && (r_slot == SB'(i))) begin
               r_len[i] <= w_wr_ptr_nxt;
            end
         end
      end
   end

   // Playback fetch pointer, delivered counter and in-flight flag
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rd_ptr    <= '0;
         r_delivered <= '0;
         r_pend      <= 1'b0;
      end else begin
         if (w_start_play) begin
            r_rd_ptr <= '0;
         end else if (w_issue) begin
            r_rd_ptr <= (LOOP_EN && ((r_rd_ptr + C_ONE) == w_cur_len)) ? '0 : r_rd_ptr + C_ONE;
         end

         if (w_start_play) begin
            r_delivered <= '0;
         end else if ((r_state == ST_PLAY) && w_rd_hs) begin
            r_delivered <= (LOOP_EN && ((r_delivered + C_ONE) == w_cur_len)) ? '0 : r_delivered + C_ONE;
         end

         // Leaving PLAY discards a fetch still in flight
         r_pend <= (w_state_nxt == ST_PLAY) && w_issue;
      end
   end

   // Read output register: loaded when the fetched word arrives, held while stalled
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rd_valid     <= 1'b0;
         r_rd_octave    <= OCTAVE_BITS'(RST_OCTAVE);
         r_rd_note      <= '0;
         r_rd_length    <= '0;
         r_rd_full_note <= FULL_NOTE_BITS'(RST_FULL_NOTE);
      end else if (w_state_nxt != ST_PLAY) begin
         r_rd_valid <= 1'b0;
      end else if (r_pend) begin
         r_rd_valid     <= 1'b1;
         r_rd_octave    <= w_ram_q[W-1 -: OCTAVE_BITS];
         r_rd_note      <= w_ram_q[W-OCTAVE_BITS-1 -: NOTE_BITS];
         r_rd_length    <= w_ram_q[FULL_NOTE_BITS +: LENGTH_BITS];
         r_rd_full_note <= w_ram_q[0 +: FULL_NOTE_BITS];
      end else if (w_rd_hs) begin
         r_rd_valid <= 1'b0;
      end
   end

   note_rec_ram #(
      .ADDR_W (AW),
      .DATA_W (W),
      .DEPTH  (SLOTS * (2 ** DEPTH_BITS))
   ) u_ram (
      .clk     (clk),
      .i_we    (w_wr_hs),
      .i_waddr ({r_slot, r_wr_ptr[DEPTH_BITS-1:0]}),
      .i_wdata ({bus.wr_octave, bus.wr_note, bus.wr_length, bus.wr_full_note}),
      .i_raddr ({r_slot, r_rd_ptr[DEPTH_BITS-1:0]}),
      .o_rdata (w_ram_q)
   );

   assign bus.wr_ready     = r_wr_ready;
   assign bus.full         = r_full;
   assign bus.busy         = r_busy;
   assign bus.done         = r_done;
   assign bus.count        = w_count;
   assign bus.rd_valid     = r_rd_valid;
   assign bus.rd_octave    = r_rd_octave;
   assign bus.rd_note      = r_rd_note;
   assign bus.rd_length    = r_rd_length;
   assign bus.rd_full_note = r_rd_full_note;

endmodule

// File: tb/tb_note_rec_bank.sv
// -----------------------------------------------------------------------------
// tb_note_rec_bank
// Directed self-checking bench for note_rec_bank with default parameters.
// -----------------------------------------------------------------------------
module tb_note_rec_bank;
   logic clk;
   logic rst_n;
   int   n_checks;
   int   n_errors;

   note_rec_bank_if bus ();

   note_rec_bank dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [11:0] pack(input int o, input int n, input int l, input int f);
      logic [2:0] o3, n3, l3, f3;
      o3 = 3'(o); n3 = 3'(n); l3 = 3'(l); f3 = 3'(f);
      return {o3, n3, l3, f3};
   endfunction

   function automatic logic [11:0] rd_word();
      return {bus.rd_octave, bus.rd_note, bus.rd_length, bus.rd_full_note};
   endfunction

   task automatic cmd(input logic [1:0] m, input int s);
      bus.mode     = m;
      bus.slot_sel = 2'(s);
      bus.start    = 1'b1;
      tick();
      bus.start = 1'b0;
      bus.mode  = 2'b00;
   endtask

   task automatic wr_entry(input int o, input int n, input int l, input int f);
      bus.wr_valid     = 1'b1;
      bus.wr_octave    = 3'(o);
      bus.wr_note      = 3'(n);
      bus.wr_length    = 3'(l);
      bus.wr_full_note = 3'(f);
      tick();
      bus.wr_valid = 1'b0;
   endtask

   task automatic do_stop;
      bus.stop = 1'b1;
      tick();
      bus.stop = 1'b0;
   endtask

   task automatic wait_valid(input string tag);
      int n;
      n = 0;
      while (!bus.rd_valid && n < 20) begin
         tick();
         n++;
      end
      chk(tag, 32'(bus.rd_valid), 32'd1);
   endtask

   task automatic len_of(input int s, input int exp, input string tag);
      bus.slot_sel = 2'(s);
      #1;
      chk(tag, 32'(bus.count), 32'(exp));
   endtask

   initial begin
      n_checks = 0;
      n_errors = 0;
      rst_n = 1'b0;
      bus.mode = 2'b00; bus.slot_sel = 2'd0; bus.start = 1'b0; bus.stop = 1'b0;
      bus.wr_valid = 1'b0; bus.wr_octave = 3'd0; bus.wr_note = 3'd0;
      bus.wr_length = 3'd0; bus.wr_full_note = 3'd0; bus.rd_ready = 1'b0;
      tick(); tick();
      chk("rst_busy",     32'(bus.busy),     32'd0);
      chk("rst_wr_ready", 32'(bus.wr_ready), 32'd0);
      chk("rst_rd_valid", 32'(bus.rd_valid), 32'd0);
      chk("rst_full",     32'(bus.full),     32'd0);
      chk("rst_done",     32'(bus.done),     32'd0);
      chk("rst_rd_word",  32'(rd_word()),    32'(pack(4, 0, 0, 4)));
      chk("rst_count",    32'(bus.count),    32'd0);
      rst_n = 1'b1;
      tick();

      // Record three entries into slot 1
      cmd(2'b01, 1);
      chk("rec_busy",     32'(bus.busy),     32'd1);
      chk("rec_wr_ready", 32'(bus.wr_ready), 32'd1);
      wr_entry(5, 1, 2, 4);
      wr_entry(4, 3, 1, 4);
      wr_entry(6, 7, 3, 2);
      chk("rec_count3", 32'(bus.count), 32'd3);
      do_stop();
      chk("rec_done", 32'(bus.done), 32'd1);
      chk("rec_idle", 32'(bus.busy), 32'd0);
      tick();
      chk("rec_done_pulse", 32'(bus.done), 32'd0);
      len_of(1, 3, "len_slot1");
      len_of(0, 0, "len_slot0");

      // Play slot 1 with the consumer always ready
      bus.rd_ready = 1'b1;
      cmd(2'b10, 1);
      chk("play_lat0", 32'(bus.rd_valid), 32'd0);
      tick();
      chk("play_lat1", 32'(bus.rd_valid), 32'd0);
      tick();
      chk("play_lat2", 32'(bus.rd_valid), 32'd1);
      chk("play_e0", 32'(rd_word()), 32'(pack(5, 1, 2, 4)));
      tick();
      wait_valid("play_v1");
      chk("play_e1", 32'(rd_word()), 32'(pack(4, 3, 1, 4)));
      tick();
      wait_valid("play_v2");
      chk("play_e2", 32'(rd_word()), 32'(pack(6, 7, 3, 2)));
      chk("play_done_early", 32'(bus.done), 32'd0);
      tick();
      chk("play_done", 32'(bus.done), 32'd1);
      chk("play_end_valid", 32'(bus.rd_valid), 32'd0);
      chk("play_end_busy", 32'(bus.busy), 32'd0);
      tick();

      // Play slot 1 with the consumer stalled: the first entry must hold
      bus.rd_ready = 1'b0;
      cmd(2'b10, 1);
      tick(); tick();
      for (int i = 0; i < 4; i++) begin
         chk("stall_valid", 32'(bus.rd_valid), 32'd1);
         chk("stall_word",  32'(rd_word()),    32'(pack(5, 1, 2, 4)));
         tick();
      end
      chk("stall_count", 32'(bus.count), 32'd0);
      do_stop();
      chk("pstop_done",  32'(bus.done),     32'd1);
      chk("pstop_valid", 32'(bus.rd_valid), 32'd0);
      tick();

      // Fill slot 2 past capacity
      cmd(2'b01, 2);
      for (int i = 0; i < 33; i++) begin
         bus.wr_valid = 1'b1;
         bus.wr_octave = 3'(i); bus.wr_note = 3'(i >> 3);
         bus.wr_length = 3'd0;  bus.wr_full_note = 3'd1;
         tick();
         if (i == 30) begin
            chk("fill31_ready", 32'(bus.wr_ready), 32'd1);
            chk("fill31_full",  32'(bus.full),     32'd0);
         end
      end
      bus.wr_valid = 1'b0;
      chk("fill_ready", 32'(bus.wr_ready), 32'd0);
      chk("fill_full",  32'(bus.full),     32'd1);
      chk("fill_count", 32'(bus.count),    32'd32);
      do_stop();
      len_of(2, 32, "len_slot2");

      // Stop together with the fifth write handshake
      cmd(2'b01, 3);
      for (int i = 0; i < 4; i++) wr_entry(i, 1, 1, 1);
      bus.wr_valid = 1'b1;
      bus.stop = 1'b1;
      tick();
      bus.wr_valid = 1'b0;
      bus.stop = 1'b0;
      chk("stop5_done", 32'(bus.done), 32'd1);
      len_of(3, 5, "len_slot3");
      tick();

      // Play an empty slot
      cmd(2'b10, 0);
      chk("empty_done",  32'(bus.done),     32'd1);
      chk("empty_busy",  32'(bus.busy),     32'd0);
      chk("empty_valid", 32'(bus.rd_valid), 32'd0);
      tick();
      chk("empty_done_off", 32'(bus.done), 32'd0);
      chk("empty_valid2",   32'(bus.rd_valid), 32'd0);

      // Reset in the middle of playback
      cmd(2'b10, 1);
      tick(); tick();
      chk("mid_valid", 32'(bus.rd_valid), 32'd1);
      rst_n = 1'b0;
      #1;
      chk("arst_valid", 32'(bus.rd_valid), 32'd0);
      chk("arst_busy",  32'(bus.busy),     32'd0);
      chk("arst_done",  32'(bus.done),     32'd0);
      chk("arst_word",  32'(rd_word()),    32'(pack(4, 0, 0, 4)));
      tick();
      chk("arst_done2", 32'(bus.done), 32'd0);
      rst_n = 1'b1;
      tick();
      chk("post_rst_done", 32'(bus.done), 32'd0);
      for (int s = 0; s < 4; s++) len_of(s, 0, "post_rst_len");

      // CLEAR a recorded slot
      cmd(2'b01, 1);
      wr_entry(2, 5, 1, 3);
      wr_entry(7, 0, 6, 1);
      do_stop();
      tick();
      len_of(1, 2, "pre_clear_len");
      cmd(2'b11, 1);
      chk("clear_busy", 32'(bus.busy), 32'd0);
      chk("clear_done", 32'(bus.done), 32'd0);
      len_of(1, 0, "clear_len");

      // Two-entry slot for the final playback
      cmd(2'b01, 1);
      wr_entry(2, 5, 1, 3);
      wr_entry(7, 0, 6, 1);
      do_stop();
      tick();
      bus.rd_ready = 1'b1;
      cmd(2'b10, 1);
`ifdef NOTE_REC_LOOP_EN
      for (int k = 0; k < 4; k++) begin
         wait_valid("loop_valid");
         chk("loop_word", 32'(rd_word()), (k % 2 == 0) ? 32'(pack(2, 5, 1, 3)) : 32'(pack(7, 0, 6, 1)));
         tick();
      end
      chk("loop_busy", 32'(bus.busy), 32'd1);
      chk("loop_no_done", 32'(bus.done), 32'd0);
      do_stop();
      chk("loop_done",  32'(bus.done),     32'd1);
      chk("loop_valid0", 32'(bus.rd_valid), 32'd0);
`else
      wait_valid("two_v0");
      chk("two_e0", 32'(rd_word()), 32'(pack(2, 5, 1, 3)));
      tick();
      wait_valid("two_v1");
      chk("two_e1", 32'(rd_word()), 32'(pack(7, 0, 6, 1)));
      tick();
      chk("two_done",   32'(bus.done),     32'd1);
      chk("two_valid0", 32'(bus.rd_valid), 32'd0);
`endif
      tick();

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
